// File: rtl/rf_pkg.sv
// Shared defaults and the write-qualification helper for the pipelined register file.
package rf_pkg;

  localparam int RF_DATA_W = 8;
  localparam int RF_ADDR_W = 3;
  localparam int RF_NUM_RD = 2;

  // A write commits unless it targets a hardwired-zero register 0.
  function automatic logic rf_writable(input logic [31:0] addr, input logic we,
                                       input logic zero_reg);
    return we && !(zero_reg && (addr == 32'd0));
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One read port: write bypass, zero-register gating and the ID/EXE latch slice.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rf_reset,
  input  logic              hold,
  input  logic              flush,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] stored,
  output logic [DATA_W-1:0] data
);

  logic [DATA_W-1:0] read_val;

  always_comb begin
    read_val = stored;
    if (wr_en && (waddr == raddr)) read_val = wdata;
    // Gate after the bypass so r0 stays zero even when a write targets it.
    if ((ZERO_REG != 0) && (raddr == '0)) read_val = '0;
  end

  always_ff @(posedge clk) begin
    if (rf_reset)   data <= '0;
    else if (flush) data <= '0;
    else if (!hold) data <= read_val;
  end

endmodule

// File: rtl/rf_pipe_regfile.sv
// Parametrised register file with registered multi-port reads, bypass, hold and flush.
module rf_pipe_regfile
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_RD   = RF_NUM_RD,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rf_reset,
  input  logic                     rf_we,
  input  logic [ADDR_W-1:0]        rf_waddr,
  input  logic [DATA_W-1:0]        rf_wdata,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  input  logic                     hold,
  input  logic                     flush,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic                     rd_valid
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_en;

  assign wr_en = rf_writable(32'(rf_waddr), rf_we, ZERO_REG != 0);

  // rd_valid marks the latch as holding a loaded operand set; it follows the
  // same reset > flush > hold > load priority as the data slices.
  always_ff @(posedge clk) begin
    if (rf_reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (wr_en) mem[rf_waddr] <= rf_wdata;
      if (flush)      rd_valid <= 1'b0;
      else if (!hold) rd_valid <= 1'b1;
    end
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [ADDR_W-1:0] raddr;
    logic [DATA_W-1:0] stored;

    assign raddr  = rd_addr[gi*ADDR_W +: ADDR_W];
    assign stored = mem[raddr];

    rf_read_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .ZERO_REG(ZERO_REG)
    ) u_port (
      .clk     (clk),
      .rf_reset(rf_reset),
      .hold    (hold),
      .flush   (flush),
      .raddr   (raddr),
      .wr_en   (wr_en),
      .waddr   (rf_waddr),
      .wdata   (rf_wdata),
      .stored  (stored),
      .data    (rd_data[gi*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_rf_pipe_regfile.sv
// Bench for rf_pipe_regfile: two instances (ZERO_REG=1 and 0) against a behavioural model.
module tb_rf_pipe_regfile;

  logic        clk = 1'b0;
  logic        rf_reset = 1'b1;
  logic        rf_we = 1'b0;
  logic [2:0]  rf_waddr = '0;
  logic [7:0]  rf_wdata = '0;
  logic [5:0]  rd_addr = '0;
  logic        hold = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] d_z1, d_z0;
  logic        v_z1, v_z0;

  int vectors = 0;
  int miscompares = 0;
  bit chk = 1'b0;

  // model state, first index: 1 = zero register hardwired, 0 = plain
  logic [7:0] mdl_mem [2][8];
  logic [7:0] mdl_lat [2][2];
  logic       mdl_v   [2];

  always #5 clk = ~clk;

  rf_pipe_regfile #(.DATA_W(8), .ADDR_W(3), .NUM_RD(2), .ZERO_REG(1)) dut_z1 (
    .clk(clk), .rf_reset(rf_reset), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .rd_addr(rd_addr), .hold(hold), .flush(flush),
    .rd_data(d_z1), .rd_valid(v_z1)
  );

  rf_pipe_regfile #(.DATA_W(8), .ADDR_W(3), .NUM_RD(2), .ZERO_REG(0)) dut_z0 (
    .clk(clk), .rf_reset(rf_reset), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .rd_addr(rd_addr), .hold(hold), .flush(flush),
    .rd_data(d_z0), .rd_valid(v_z0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // What one clock edge does to the register file, from the operational rules.
  task automatic model_edge();
    logic [7:0] rv [2];
    logic       eff;
    logic [2:0] a;
    for (int z = 0; z < 2; z++) begin
      if (rf_reset) begin
        for (int k = 0; k < 8; k++) mdl_mem[z][k] = 8'h00;
        mdl_lat[z][0] = 8'h00;
        mdl_lat[z][1] = 8'h00;
        mdl_v[z] = 1'b0;
      end else begin
        eff = rf_we && !(z == 1 && rf_waddr == 3'd0);
        for (int p = 0; p < 2; p++) begin
          a = rd_addr[p*3 +: 3];
          if (z == 1 && a == 3'd0)        rv[p] = 8'h00;
          else if (eff && rf_waddr == a)  rv[p] = rf_wdata;
          else                            rv[p] = mdl_mem[z][a];
        end
        if (flush) begin
          mdl_lat[z][0] = 8'h00;
          mdl_lat[z][1] = 8'h00;
          mdl_v[z] = 1'b0;
        end else if (!hold) begin
          mdl_lat[z][0] = rv[0];
          mdl_lat[z][1] = rv[1];
          mdl_v[z] = 1'b1;
        end
        if (eff) mdl_mem[z][rf_waddr] = rf_wdata;
      end
    end
    if (rf_reset) chk = 1'b1;
  endtask

  task automatic cyc(input logic rst, input logic we, input logic [2:0] wa,
                     input logic [7:0] wd, input logic [2:0] a1, input logic [2:0] a0,
                     input logic h, input logic f);
    rf_reset = rst;
    rf_we    = we;
    rf_waddr = wa;
    rf_wdata = wd;
    rd_addr  = {a1, a0};
    hold     = h;
    flush    = f;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  // Compare process: every cycle once the design has seen a reset.
  always @(negedge clk) begin
    if (chk) begin
      check("z1_port0", {24'd0, d_z1[7:0]},  {24'd0, mdl_lat[1][0]});
      check("z1_port1", {24'd0, d_z1[15:8]}, {24'd0, mdl_lat[1][1]});
      check("z1_valid", {31'd0, v_z1},       {31'd0, mdl_v[1]});
      check("z0_port0", {24'd0, d_z0[7:0]},  {24'd0, mdl_lat[0][0]});
      check("z0_port1", {24'd0, d_z0[15:8]}, {24'd0, mdl_lat[0][1]});
      check("z0_valid", {31'd0, v_z0},       {31'd0, mdl_v[0]});
    end
  end

  initial begin
    // reset for two cycles
    cyc(1, 0, 0, 8'h00, 0, 0, 0, 0);
    check("lit_reset_valid", {31'd0, v_z1}, 32'd0);
    check("lit_reset_data", {16'd0, d_z1}, 32'd0);
    cyc(1, 0, 0, 8'h00, 0, 0, 0, 0);

    // read all addresses after reset
    for (int a = 0; a < 8; a++) begin
      cyc(0, 0, 0, 8'h00, 3'(a), 3'(a), 0, 0);
      check("lit_post_reset_data", {16'd0, d_z1}, 32'd0);
      check("lit_post_reset_valid", {31'd0, v_z1}, 32'd1);
    end

    // write and read back
    cyc(0, 1, 3, 8'hA5, 0, 0, 0, 0);
    cyc(0, 1, 5, 8'h3C, 0, 0, 0, 0);
    cyc(0, 0, 0, 8'h00, 5, 3, 0, 0);
    check("lit_readback_p0", {24'd0, d_z1[7:0]}, 32'hA5);
    check("lit_readback_p1", {24'd0, d_z1[15:8]}, 32'h3C);

    // same-cycle bypass
    cyc(0, 1, 2, 8'h77, 0, 2, 0, 0);
    check("lit_bypass", {24'd0, d_z1[7:0]}, 32'h77);

    // zero register behaviour differs between the two instances
    cyc(0, 1, 0, 8'hFF, 0, 0, 0, 0);
    cyc(0, 0, 0, 8'h00, 0, 0, 0, 0);
    check("lit_zero_reg1", {24'd0, d_z1[7:0]}, 32'h00);
    check("lit_zero_reg0", {24'd0, d_z0[7:0]}, 32'hFF);

    // hold while r3 is rewritten, then flush+hold, then release
    cyc(0, 0, 0, 8'h00, 3, 3, 0, 0);
    check("lit_latch_r3", {24'd0, d_z1[7:0]}, 32'hA5);
    for (int i = 0; i < 3; i++) begin
      cyc(0, (i == 0), 3, 8'h11, 3, 3, 1, 0);
      check("lit_hold_stale", {24'd0, d_z1[7:0]}, 32'hA5);
    end
    cyc(0, 0, 0, 8'h00, 3, 3, 1, 1);
    check("lit_flush_data", {16'd0, d_z1}, 32'd0);
    check("lit_flush_valid", {31'd0, v_z1}, 32'd0);
    cyc(0, 0, 0, 8'h00, 3, 3, 0, 0);
    check("lit_release", {24'd0, d_z1[7:0]}, 32'h11);

    // reset mid-operation with a colliding write and hold
    cyc(1, 1, 4, 8'h5A, 4, 4, 1, 0);
    check("lit_midreset_data", {16'd0, d_z1}, 32'd0);
    check("lit_midreset_valid", {31'd0, v_z1}, 32'd0);
    cyc(0, 0, 0, 8'h00, 4, 4, 0, 0);
    check("lit_r4_lost", {16'd0, d_z0}, 32'd0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 49) == 0),
          ($urandom_range(0, 1) == 1),
          3'($urandom_range(0, 7)),
          8'($urandom_range(0, 255)),
          3'($urandom_range(0, 7)),
          3'($urandom_range(0, 7)),
          ($urandom_range(0, 4) == 0),
          ($urandom_range(0, 9) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rf_pipe_regfile.md
# rf_pipe_regfile

Parametrised register file with an integrated ID/EXE read latch, the successor to the fixed 8-bit, two-read-port register file in the RISC core. Each of NUM_RD read ports samples its operand into a registered output stage. Write-to-read bypass removes the same-cycle write/read hazard. Pipeline hold and flush controls let the core stall or squash the decode stage without external muxing.

## Interface
Parameters:
- DATA_W, 8, register and data width
- ADDR_W, 3, register address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 hardwired to zero (writes to it discarded)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rf_reset  in  1  synchronous, active-high reset
- rf_we  in  1  write enable
- rf_waddr  in  ADDR_W  write address
- rf_wdata  in  DATA_W  write data
- rd_addr  in  NUM_RD*ADDR_W  read addresses, port i at bits [i*ADDR_W +: ADDR_W]
- hold  in  1  stall: keep the read latch contents
- flush  in  1  squash: clear the read latch
- rd_data  out  NUM_RD*DATA_W  latched operands, port i at bits [i*DATA_W +: DATA_W]
- rd_valid  out  1  latch holds a valid operand set

## Operation
- Storage: 2**ADDR_W words of DATA_W bits.
- Write is effective when rf_we=1 and not (ZERO_REG=1 and rf_waddr=0). An effective write updates the addressed word at the clock edge.
- Read value for port i: if there is an effective write and rf_waddr == rd_addr[i], the value is rf_wdata (bypass); otherwise it is the stored word.
- With ZERO_REG=1, a read of address 0 always returns 0. This holds even when rf_we targets address 0.
- Read latch priority per edge is rf_reset > flush > hold > load.
  - rf_reset: rd_data=0, rd_valid=0.
  - flush: rd_data=0, rd_valid=0.
  - hold: rd_data and rd_valid unchanged.
  - load: rd_data = read values, rd_valid=1.
- The write path is independent of hold and flush. An effective write always commits unless rf_reset=1.
- All ports read concurrently. Duplicate read addresses return identical data.

## Timing
- Reset: all storage words, rd_data and rd_valid are 0 at the first edge with rf_reset=1.
- rf_reset overrides a simultaneous write; the write is lost.
- Reset is accepted mid-operation on any cycle. Hold and flush are ignored in that cycle.
- Read latency: 1 cycle. rd_addr sampled at edge N appears on rd_data after edge N.
- Write latency: data written at edge N is visible to a read sampled at edge N via the bypass. It is visible from storage at edge N+1 onwards.
- While hold=1, rd_data does not track later writes to the latched addresses. The stale value is intended; forwarding beyond this stage belongs to the EXE stage.
- No combinational path from inputs to rd_data or rd_valid.

## Structure
- Package rf_pkg holds:
  - default DATA_W/ADDR_W/NUM_RD constants;
  - a function rf_writable(addr, we, zero_reg) returning the effective-write condition.
- Sub-module rf_read_port is instantiated NUM_RD times via generate. It contains one bypass mux, the zero-register gating, and that port's DATA_W latch slice with the reset/flush/hold priority.
- The top level owns the storage array, the write logic and rd_valid.

## Test plan
- Reset then read all addresses: hold rf_reset=1 for 2 cycles, then read r0..r7 on both ports -> rd_data=0 everywhere, rd_valid=0 during reset and 1 from the first load after release.
- Write and read back: write r3=0xA5 and r5=0x3C, then read rd_addr={5,3} -> port0=0xA5, port1=0x3C one cycle later.
- Same-cycle bypass: write r2=0x77 while reading r2 on port 0 in the same cycle -> rd_data port0=0x77 after that edge, not the old value.
- Zero register: write r0=0xFF with ZERO_REG=1, then read r0 -> 0x00; repeat the same stimulus with ZERO_REG=0 -> 0xFF.
- Hold and flush:
  - latch r3=0xA5, then assert hold for 3 cycles while writing r3=0x11 -> rd_data stays 0xA5;
  - assert flush and hold together -> rd_data=0, rd_valid=0;
  - release both -> 0x11.
- Reset mid-operation: assert rf_reset on the same edge as a write r4=0x5A with hold=1 -> r4 reads 0 after release, and rd_data=0, rd_valid=0.
